fb_pixel_writer: RTL and testbench

//  Pixel-stream sink for the GPU draw primitives: accepts (x,y) pixel strobes from drawbitmap/line/rect

---
 rtl/fb_pixel_writer_pkg.sv | 25 ++
 rtl/fb_pixel_writer_addr_calc.sv | 29 ++
 rtl/fb_pixel_writer.sv | 186 ++++++++++++++++++
 tb/tb_fb_pixel_writer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pixel_writer_pkg.sv
// Shared constants, FSM state encoding and bit-merge helper for the 1bpp framebuffer pixel writer.
// States are one-hot so they line up with the other GPU engines.
package fb_pixel_writer_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FB_WIDTH   = 240;
    localparam int DEF_FB_HEIGHT  = 240;
    localparam int BYTES_PER_ROW  = DEF_FB_WIDTH / 8;
    localparam int DEF_ADDR_WIDTH = 13;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_RD   = 5'b00010,
        ST_RDW  = 5'b00100,
        ST_HOLD = 5'b01000,
        ST_WB   = 5'b10000
    } state_t;

    function automatic logic [7:0] merge_pixel(input logic [7:0] byte_in,
                                               input logic [7:0] mask,
                                               input logic       color);
        return color ? (byte_in | mask) : (byte_in & ~mask);
    endfunction

endpackage

// File: rtl/fb_pixel_writer_addr_calc.sv
// Combinational pixel-to-byte mapping: byte address, one-hot bit mask (MSB = leftmost) and clip flag.
// The row multiply is a fixed *30 built from shifts, so it assumes a 240-column framebuffer.
module fb_pixel_writer_addr_calc
    import fb_pixel_writer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FB_WIDTH   = DEF_FB_WIDTH,
    parameter int FB_HEIGHT  = DEF_FB_HEIGHT,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] pix_x,
    input  logic [DATA_WIDTH-1:0] pix_y,
    output logic [ADDR_WIDTH-1:0] byte_addr,
    output logic [7:0]            bit_mask,
    output logic                  in_range
);

    logic [ADDR_WIDTH-1:0] y_ext;
    logic [ADDR_WIDTH-1:0] x_byte;

    always_comb begin
        y_ext     = ADDR_WIDTH'(pix_y);
        x_byte    = ADDR_WIDTH'(pix_x[DATA_WIDTH-1:3]);
        byte_addr = (y_ext << 5) - (y_ext << 1) + x_byte;
        bit_mask  = 8'h80 >> pix_x[2:0];
        in_range  = (int'(pix_x) < FB_WIDTH) && (int'(pix_y) < FB_HEIGHT);
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Pixel-stream sink: plots (x,y) strobes into a 1bpp framebuffer via byte read-modify-write,
// coalescing runs of pixels that land in the same byte into a single RMW.
module fb_pixel_writer
    import fb_pixel_writer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FB_WIDTH   = DEF_FB_WIDTH,
    parameter int FB_HEIGHT  = DEF_FB_HEIGHT,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_valid,
    input  logic [DATA_WIDTH-1:0] pix_x,
    input  logic [DATA_WIDTH-1:0] pix_y,
    input  logic                  pix_color,
    output logic                  pix_ready,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic                  fb_rd_en,
    input  logic [7:0]            fb_rd_data,
    output logic                  fb_wr_en,
    output logic [7:0]            fb_wr_data
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            mask_q, mask_d;
    logic                  color_q, color_d;
    logic [7:0]            cache_q, cache_d;
    logic                  pend_q, pend_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
    logic                  fb_rd_en_q, fb_rd_en_d;
    logic                  fb_wr_en_q, fb_wr_en_d;
    logic [7:0]            fb_wr_data_q, fb_wr_data_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH-1:0] calc_addr;
    logic [7:0]            calc_mask;
    logic                  calc_in_range;
    logic                  take;
    logic                  same_byte;
    logic [7:0]            merged;

    fb_pixel_writer_addr_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .FB_WIDTH   (FB_WIDTH),
        .FB_HEIGHT  (FB_HEIGHT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_calc (
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .byte_addr (calc_addr),
        .bit_mask  (calc_mask),
        .in_range  (calc_in_range)
    );

    assign pix_ready  = ((state_q == ST_IDLE) || (state_q == ST_HOLD)) && !reset;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign fb_addr    = fb_addr_q;
    assign fb_rd_en   = fb_rd_en_q;
    assign fb_wr_en   = fb_wr_en_q;
    assign fb_wr_data = fb_wr_data_q;

    // Clipped pixels are still consumed; they just never reach memory.
    assign take      = pix_valid && pix_ready && calc_in_range;
    assign same_byte = (calc_addr == addr_q);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        mask_d       = mask_q;
        color_d      = color_q;
        cache_d      = cache_q;
        pend_d       = pend_q;
        flush_pend_d = flush_pend_q;
        fb_addr_d    = fb_addr_q;
        fb_rd_en_d   = 1'b0;
        fb_wr_en_d   = 1'b0;
        fb_wr_data_d = fb_wr_data_q;
        done_d       = 1'b0;
        merged       = cache_q;

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    addr_d       = calc_addr;
                    mask_d       = calc_mask;
                    color_d      = pix_color;
                    fb_addr_d    = calc_addr;
                    fb_rd_en_d   = 1'b1;
                    flush_pend_d = flush;
                    state_d      = ST_RD;
                end else if (flush) begin
                    done_d = 1'b1;
                end
            end
            ST_RD: begin
                state_d = ST_RDW;
            end
            ST_RDW: begin
                cache_d = merge_pixel(fb_rd_data, mask_q, color_q);
                // A flush seen earlier goes straight to write-back without reopening for pixels.
                if (flush_pend_q) begin
                    fb_wr_en_d   = 1'b1;
                    fb_wr_data_d = cache_d;
                    state_d      = ST_WB;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (take && same_byte) begin
                    merged = merge_pixel(cache_q, calc_mask, pix_color);
                end
                cache_d = merged;
                if (take && !same_byte) begin
                    // fb_addr still points at the cached byte for this write; the new pixel waits as pending.
                    fb_wr_en_d   = 1'b1;
                    fb_wr_data_d = cache_q;
                    addr_d       = calc_addr;
                    mask_d       = calc_mask;
                    color_d      = pix_color;
                    pend_d       = 1'b1;
                    flush_pend_d = flush;
                    state_d      = ST_WB;
                end else if (flush) begin
                    fb_wr_en_d   = 1'b1;
                    fb_wr_data_d = merged;
                    flush_pend_d = 1'b1;
                    state_d      = ST_WB;
                end
            end
            ST_WB: begin
                if (pend_q) begin
                    pend_d     = 1'b0;
                    fb_addr_d  = addr_q;
                    fb_rd_en_d = 1'b1;
                    state_d    = ST_RD;
                end else begin
                    done_d       = flush_pend_q;
                    flush_pend_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            mask_q       <= '0;
            color_q      <= 1'b0;
            cache_q      <= '0;
            pend_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            fb_addr_q    <= '0;
            fb_rd_en_q   <= 1'b0;
            fb_wr_en_q   <= 1'b0;
            fb_wr_data_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            mask_q       <= mask_d;
            color_q      <= color_d;
            cache_q      <= cache_d;
            pend_q       <= pend_d;
            flush_pend_q <= flush_pend_d;
            fb_addr_q    <= fb_addr_d;
            fb_rd_en_q   <= fb_rd_en_d;
            fb_wr_en_q   <= fb_wr_en_d;
            fb_wr_data_q <= fb_wr_data_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: 1-cycle RAM model, vector table, corner-case sequences, and a
// randomized pixel stream checked against a shadow framebuffer with run-based write prediction.
module tb_fb_pixel_writer;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_valid;
    logic [7:0]    pix_x;
    logic [7:0]    pix_y;
    logic          pix_color;
    logic          pix_ready;
    logic          flush;
    logic          busy;
    logic          done;
    logic [AW-1:0] fb_addr;
    logic          fb_rd_en;
    logic [7:0]    fb_rd_data;
    logic          fb_wr_en;
    logic [7:0]    fb_wr_data;

    always #5 clk = ~clk;

    fb_pixel_writer dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_color  (pix_color),
        .pix_ready  (pix_ready),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .fb_addr    (fb_addr),
        .fb_rd_en   (fb_rd_en),
        .fb_rd_data (fb_rd_data),
        .fb_wr_en   (fb_wr_en),
        .fb_wr_data (fb_wr_data)
    );

    // RAM model with a side port for preloading; it also logs every memory transaction.
    logic [7:0]    ram [0:8191];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [7:0]    pre_data = '0;
    int            rd_cnt = 0;
    int            done_cnt = 0;
    int            both_cnt = 0;
    int            wr_a_q[$];
    int            wr_d_q[$];

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        if (fb_rd_en) begin
            fb_rd_data <= ram[fb_addr];
            rd_cnt     <= rd_cnt + 1;
        end
        if (fb_wr_en) begin
            ram[fb_addr] <= fb_wr_data;
            wr_a_q.push_back(int'(fb_addr));
            wr_d_q.push_back(int'(fb_wr_data));
        end
        if (fb_rd_en && fb_wr_en) both_cnt <= both_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic poke(input int a, input int d);
        pre_addr = AW'(a);
        pre_data = 8'(d);
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_pix(input int x, input int y, input bit c, input bit fl, output int stalls);
        pix_valid = 1'b1;
        pix_x     = 8'(x);
        pix_y     = 8'(y);
        pix_color = c;
        flush     = fl;
        stalls    = 0;
        while (!pix_ready && stalls < 50) begin
            @(negedge clk);
            stalls++;
        end
        if (!pix_ready) chk("pix_accept_timeout", 0, 1);
        @(negedge clk);
        pix_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic send_flush(output int stalls);
        flush  = 1'b1;
        stalls = 0;
        while (!pix_ready && stalls < 50) begin
            @(negedge clk);
            stalls++;
        end
        if (!pix_ready) chk("flush_accept_timeout", 0, 1);
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) chk({name, "_idle_timeout"}, 0, 1);
    endtask

    typedef struct {
        int x;
        int y;
        bit color;
        int pre;
        int exp_wrs;
        int exp_addr;
        int exp_data;
    } vec_t;

    vec_t vecs[8];

    // Shadow framebuffer and expected write stream for the random phase.
    int  ref_fb [0:8191];
    int  exp_a_q[$];
    int  exp_d_q[$];
    int  run_addr;
    bit  run_open;
    int  exp_done;

    task automatic close_run();
        exp_a_q.push_back(run_addr);
        exp_d_q.push_back(ref_fb[run_addr]);
        run_open = 1'b0;
    endtask

    task automatic model_pix(input int x, input int y, input bit c, input bit fl);
        int a;
        int m;
        if (x < 240 && y < 240) begin
            a = y * 30 + x / 8;
            m = 128 >> (x % 8);
            if (run_open && a != run_addr) close_run();
            run_open = 1'b1;
            run_addr = a;
            ref_fb[a] = c ? (ref_fb[a] | m) : (ref_fb[a] & ~m & 255);
        end
        if (fl) begin
            if (run_open) close_run();
            exp_done++;
        end
    endtask

    int st, st_sum, bw, br, bd, px, py, pc, pf, nw;

    initial begin
        vecs[0] = '{x: 3,   y: 0,   color: 1'b1, pre: 8'h00, exp_wrs: 1, exp_addr: 0,    exp_data: 8'h10};
        vecs[1] = '{x: 0,   y: 0,   color: 1'b1, pre: 8'h00, exp_wrs: 1, exp_addr: 0,    exp_data: 8'h80};
        vecs[2] = '{x: 7,   y: 0,   color: 1'b1, pre: 8'h00, exp_wrs: 1, exp_addr: 0,    exp_data: 8'h01};
        vecs[3] = '{x: 239, y: 239, color: 1'b1, pre: 8'h00, exp_wrs: 1, exp_addr: 7199, exp_data: 8'h01};
        vecs[4] = '{x: 8,   y: 1,   color: 1'b0, pre: 8'hFF, exp_wrs: 1, exp_addr: 31,   exp_data: 8'h7F};
        vecs[5] = '{x: 240, y: 5,   color: 1'b1, pre: 8'h00, exp_wrs: 0, exp_addr: 0,    exp_data: 0};
        vecs[6] = '{x: 5,   y: 240, color: 1'b1, pre: 8'h00, exp_wrs: 0, exp_addr: 0,    exp_data: 0};
        vecs[7] = '{x: 100, y: 50,  color: 1'b1, pre: 8'hA5, exp_wrs: 1, exp_addr: 1512, exp_data: 8'hAD};

        reset = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pix_ready", int'(pix_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(fb_rd_en), 0);
        chk("rst_wr_en", int'(fb_wr_en), 0);
        chk("rst_addr", int'(fb_addr), 0);
        chk("rst_wr_data", int'(fb_wr_data), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", int'(pix_ready), 1);

        // Flush with nothing cached: done only, no memory traffic.
        bw = wr_a_q.size(); br = rd_cnt; bd = done_cnt;
        send_flush(st);
        wait_idle("idle_flush");
        chk("idle_flush_done", done_cnt - bd, 1);
        chk("idle_flush_mem", (wr_a_q.size() - bw) + (rd_cnt - br), 0);

        // Single pixel vectors followed by a flush.
        foreach (vecs[i]) begin
            if (vecs[i].exp_wrs != 0) poke(vecs[i].exp_addr, vecs[i].pre);
            bw = wr_a_q.size(); br = rd_cnt; bd = done_cnt;
            send_pix(vecs[i].x, vecs[i].y, vecs[i].color, 1'b0, st);
            send_flush(st);
            wait_idle("vec");
            chk($sformatf("vec%0d_writes", i), wr_a_q.size() - bw, vecs[i].exp_wrs);
            chk($sformatf("vec%0d_reads", i), rd_cnt - br, vecs[i].exp_wrs);
            chk($sformatf("vec%0d_done", i), done_cnt - bd, 1);
            if (vecs[i].exp_wrs == 1 && wr_a_q.size() > bw) begin
                chk($sformatf("vec%0d_addr", i), wr_a_q[bw], vecs[i].exp_addr);
                chk($sformatf("vec%0d_data", i), wr_d_q[bw], vecs[i].exp_data);
            end
        end

        // Eight pixels of one byte back-to-back: one RMW, no stalls after the initial fill.
        poke(30, 8'h00);
        bw = wr_a_q.size(); br = rd_cnt;
        st_sum = 0;
        for (int i = 0; i < 8; i++) begin
            send_pix(i, 1, 1'b1, 1'b0, st);
            if (i == 1) chk("run8_fill_stall", st, 2);
            if (i >= 2) st_sum += st;
        end
        chk("run8_stalls", st_sum, 0);
        send_flush(st);
        wait_idle("run8");
        chk("run8_writes", wr_a_q.size() - bw, 1);
        chk("run8_reads", rd_cnt - br, 1);
        if (wr_a_q.size() > bw) begin
            chk("run8_addr", wr_a_q[bw], 30);
            chk("run8_data", wr_d_q[bw], 8'hFF);
        end

        // Byte change: old byte written back, new byte fetched, 3 stall cycles.
        poke(31, 8'hFF);
        poke(32, 8'h00);
        bw = wr_a_q.size();
        send_pix(9, 1, 1'b0, 1'b0, st);
        send_pix(16, 1, 1'b1, 1'b0, st);
        send_flush(st);
        chk("bytechg_stalls", st, 3);
        wait_idle("bytechg");
        chk("bytechg_writes", wr_a_q.size() - bw, 2);
        if (wr_a_q.size() - bw == 2) begin
            chk("bytechg_addr0", wr_a_q[bw], 31);
            chk("bytechg_data0", wr_d_q[bw], 8'hBF);
            chk("bytechg_addr1", wr_a_q[bw+1], 32);
            chk("bytechg_data1", wr_d_q[bw+1], 8'h80);
        end

        // Flush together with a different-byte pixel: two writes, then one done.
        poke(0, 8'h00);
        poke(1, 8'h00);
        bw = wr_a_q.size(); bd = done_cnt;
        send_pix(0, 0, 1'b1, 1'b0, st);
        send_pix(8, 0, 1'b1, 1'b1, st);
        nw = 0;
        while (!done && nw < 50) begin
            @(negedge clk);
            nw++;
        end
        chk("simul_done_seen", int'(done), 1);
        chk("simul_writes_at_done", wr_a_q.size() - bw, 2);
        wait_idle("simul");
        chk("simul_done_count", done_cnt - bd, 1);
        if (wr_a_q.size() - bw == 2) begin
            chk("simul_addr0", wr_a_q[bw], 0);
            chk("simul_data0", wr_d_q[bw], 8'h80);
            chk("simul_addr1", wr_a_q[bw+1], 1);
            chk("simul_data1", wr_d_q[bw+1], 8'h80);
        end

        // Reset while the read data is being merged: nothing may be written.
        poke(60, 8'h00);
        bw = wr_a_q.size(); bd = done_cnt;
        send_pix(0, 2, 1'b1, 1'b1, st);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstrmw_ready", int'(pix_ready), 0);
        chk("rstrmw_busy", int'(busy), 0);
        chk("rstrmw_wr_en", int'(fb_wr_en), 0);
        chk("rstrmw_rd_en", int'(fb_rd_en), 0);
        chk("rstrmw_addr", int'(fb_addr), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rstrmw_ready_back", int'(pix_ready), 1);
        repeat (4) @(negedge clk);
        chk("rstrmw_no_write", wr_a_q.size() - bw, 0);
        chk("rstrmw_no_done", done_cnt - bd, 0);

        // Randomized stream over rows 10..17, columns 0..63, against the shadow framebuffer.
        for (int yy = 10; yy < 18; yy++) begin
            for (int b = 0; b < 8; b++) begin
                pc = int'($urandom_range(0, 255));
                ref_fb[yy*30+b] = pc;
                poke(yy*30+b, pc);
            end
        end
        exp_a_q.delete(); exp_d_q.delete();
        run_open = 1'b0; run_addr = 0; exp_done = 0;
        bw = wr_a_q.size(); br = rd_cnt; bd = done_cnt;
        px = 0; py = 10;
        for (int n = 0; n < 300; n++) begin
            pf = int'($urandom_range(0, 11));
            if (pf == 0) begin
                px = int'($urandom_range(240, 255)); py = int'($urandom_range(10, 17));
            end else if (pf == 1) begin
                px = int'($urandom_range(0, 63)); py = int'($urandom_range(240, 255));
            end else if (pf < 8 && px < 64 && py < 18) begin
                px = (px & ~7) | int'($urandom_range(0, 7));
            end else begin
                px = int'($urandom_range(0, 63)); py = int'($urandom_range(10, 17));
            end
            pc = int'($urandom_range(0, 1));
            pf = ($urandom_range(0, 7) == 0) ? 1 : 0;
            model_pix(px, py, pc[0], pf[0]);
            send_pix(px, py, pc[0], pf[0], st);
            if ($urandom_range(0, 5) == 0) repeat (int'($urandom_range(1, 3))) @(negedge clk);
        end
        model_pix(0, 255, 1'b0, 1'b1);
        send_flush(st);
        wait_idle("rand");
        chk("rand_write_count", wr_a_q.size() - bw, exp_a_q.size());
        chk("rand_read_count", rd_cnt - br, exp_a_q.size());
        chk("rand_done_count", done_cnt - bd, exp_done);
        for (int i = 0; i < exp_a_q.size() && (bw + i) < wr_a_q.size(); i++) begin
            chk($sformatf("rand_wr%0d_addr", i), wr_a_q[bw+i], exp_a_q[i]);
            chk($sformatf("rand_wr%0d_data", i), wr_d_q[bw+i], exp_d_q[i]);
        end
        for (int yy = 10; yy < 18; yy++) begin
            for (int b = 0; b < 8; b++) begin
                chk($sformatf("rand_ram_%0d", yy*30+b), int'(ram[yy*30+b]), ref_fb[yy*30+b]);
            end
        end

        chk("no_rd_wr_overlap", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
